// File: rtl/mp_pkg.sv
// Shared state type and ROM word layout for the sequencing music player.
// A ROM word is {step, dur}; dur sits in the low bits and a zero dur marks end of song.
package mp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        NOTE,
        END
    } mp_state_e;

    localparam int DUR_LSB = 0;
    localparam logic [31:0] END_MARK = 32'd0;

    // The step field starts right above the duration field.
    function automatic int step_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

endpackage

// File: rtl/mp_square_voice.sv
// Square-wave voice: phase accumulator, latched phase step and square/rest sample mux.
// The sample reflects the accumulator value after the frame that produced it.
module mp_square_voice
    import mp_pkg::*;
#(
    parameter int STEP_W = 20,
    parameter int PHASE_W = 22,
    parameter int SAMPLE_W = 16,
    parameter logic signed [SAMPLE_W-1:0] AMP = 16'sd8192
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       clear,
    input  logic                       load,
    input  logic                       enable,
    input  logic [STEP_W-1:0]          step,
    output logic signed [SAMPLE_W-1:0] sample
);

    logic [STEP_W-1:0]  step_reg;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;

    assign phase_nxt = phase + PHASE_W'(step_reg);

    // A zero step is a rest; otherwise the phase MSB picks the half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_reg <= '0;
            phase    <= '0;
            sample   <= '0;
        end else begin
            if (load) begin
                step_reg <= step;
            end
            if (clear) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase_nxt;
            end
            if (!enable || clear) begin
                sample <= '0;
            end else if (tick) begin
                sample <= (step_reg == '0) ? '0 :
                          (phase_nxt[PHASE_W-1] ? -AMP : AMP);
            end
        end
    end

endmodule

// File: rtl/music_player_seq.sv
// Multi-song player: fetches {step, dur} notes from an external ROM and plays them as square waves.
// Define MP_LOOP_EN to make the end of a song restart the same song instead of stopping.
module music_player_seq
    import mp_pkg::*;
#(
    parameter int NUM_SONGS = 4,
    parameter int NOTE_AW = 5,
    parameter int STEP_W = 20,
    parameter int DUR_W = 6,
    parameter int PHASE_W = 22,
    parameter int SAMPLE_W = 16,
    parameter logic signed [SAMPLE_W-1:0] AMP = 16'sd8192
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   play_button,
    input  logic                                   next,
    input  logic                                   prev,
    input  logic                                   New_Frame,
    output logic                                   rom_req,
    output logic [$clog2(NUM_SONGS)+NOTE_AW-1:0]   rom_addr,
    input  logic                                   rom_ack,
    input  logic [STEP_W+DUR_W-1:0]                rom_data,
    output logic signed [SAMPLE_W-1:0]             sample_out,
    output logic                                   play,
    output logic [$clog2(NUM_SONGS)-1:0]           song,
    output logic                                   song_done
);

    localparam int SONG_W = $clog2(NUM_SONGS);
    localparam int STEP_POS = step_lsb(DUR_W);

    mp_state_e          state;
    logic [NOTE_AW-1:0] note_idx;
    logic [DUR_W-1:0]   frame_cnt;
    logic [DUR_W-1:0]   dur_reg;
    logic               discard;

    logic [STEP_W-1:0]  rom_step;
    logic [DUR_W-1:0]   rom_dur;
    logic               is_end;
    logic               song_chg;
    logic               voice_tick;
    logic               voice_load;
    logic               voice_enable;

    function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s);
        return (s == SONG_W'(NUM_SONGS - 1)) ? '0 : s + SONG_W'(1);
    endfunction

    function automatic logic [SONG_W-1:0] song_dec(input logic [SONG_W-1:0] s);
        return (s == '0) ? SONG_W'(NUM_SONGS - 1) : s - SONG_W'(1);
    endfunction

    assign rom_step = rom_data[STEP_POS +: STEP_W];
    assign rom_dur  = rom_data[DUR_LSB +: DUR_W];
    assign is_end   = (rom_dur == DUR_W'(END_MARK));

    // next and prev together cancel out.
    assign song_chg     = next ^ prev;
    assign voice_tick   = (state == NOTE) && play && New_Frame && !song_chg;
    assign voice_load   = (state == FETCH) && rom_req && rom_ack && !discard && !song_chg && !is_end;
    assign voice_enable = (state == NOTE) && play;

    // A request is only launched while playing; once launched it always runs to its ack,
    // and a song change during it marks the returning word as stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            play      <= 1'b0;
            song      <= '0;
            note_idx  <= '0;
            frame_cnt <= '0;
            dur_reg   <= '0;
            rom_req   <= 1'b0;
            rom_addr  <= '0;
            song_done <= 1'b0;
            discard   <= 1'b0;
        end else begin
            song_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (play_button) begin
                        play  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (play_button) begin
                        play <= !play;
                    end
                    if (!rom_req) begin
                        if (play && !song_chg) begin
                            rom_req  <= 1'b1;
                            rom_addr <= {song, note_idx};
                        end
                    end else if (rom_ack) begin
                        rom_req <= 1'b0;
                        if (discard || song_chg) begin
                            discard <= 1'b0;
                        end else if (is_end) begin
                            state <= END;
                        end else begin
                            dur_reg   <= rom_dur;
                            frame_cnt <= '0;
                            state     <= NOTE;
                        end
                    end else if (song_chg) begin
                        discard <= 1'b1;
                    end
                end
                NOTE: begin
                    if (play_button) begin
                        play <= !play;
                    end
                    if (voice_tick) begin
                        if (frame_cnt == DUR_W'(dur_reg - DUR_W'(1))) begin
                            note_idx <= note_idx + NOTE_AW'(1);
                            state    <= (note_idx == '1) ? END : FETCH;
                        end else begin
                            frame_cnt <= frame_cnt + DUR_W'(1);
                        end
                    end
                end
                END: begin
                    song_done <= 1'b1;
                    note_idx  <= '0;
`ifdef MP_LOOP_EN
                    state     <= FETCH;
`else
                    song      <= song_inc(song);
                    play      <= 1'b0;
                    state     <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase

            if (song_chg) begin
                song     <= next ? song_inc(song) : song_dec(song);
                note_idx <= '0;
                if (state == FETCH || state == NOTE) begin
                    state <= FETCH;
                end
            end
        end
    end

    mp_square_voice #(
        .STEP_W  (STEP_W),
        .PHASE_W (PHASE_W),
        .SAMPLE_W(SAMPLE_W),
        .AMP     (AMP)
    ) u_voice (
        .clk    (clk),
        .reset  (reset),
        .tick   (voice_tick),
        .clear  (song_chg),
        .load   (voice_load),
        .enable (voice_enable),
        .step   (rom_step),
        .sample (sample_out)
    );

endmodule
